ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Receives PS/2 keyboard frames (device-clocked, 11-bit) and decodes scan-code set 2 make/break sequences. Presents the pressed key as an ASCII byte plus a level "key held" flag. Sits directly upstream of the UART transmitter: `ps2_byte` drives its `rx_data`, and `ps2_state` drives its `rx_int`. Each rising edge of `ps2_state` causes exactly one byte to be sent over RS232.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100000: `clk` cycles (2 ms at 50 MHz) without a PS/2 clock falling edge before a partial frame is aborted.

Ports:
- `clk`, input, 1: 50 MHz system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `ps2k_clk`, input, 1: PS/2 clock from the keyboard; asynchronous to `clk`.
- `ps2k_data`, input, 1: PS/2 data from the keyboard; asynchronous to `clk`.
- `ps2_byte`, output, 8: ASCII code of the last accepted make code.
- `ps2_state`, output, 1: high while a mapped key is held; low after any break.

## Operation
- **Synchronisation**
  - `ps2k_clk` passes through a 3-flop chain; `ps2k_data` passes through a 2-flop chain.
  - `fall` is a 1-cycle pulse: previous synchronised clock is 1 and current is 0.
  - Every bit is sampled on `fall`.
- **Frame FSM** (states IDLE, SHIFT; 4-bit counter `cnt`)
  - IDLE: on `fall` with data = 0 (start bit), go to SHIFT with `cnt`=1. On `fall` with data = 1, stay in IDLE.
  - SHIFT, `cnt` 1..8: shift data in LSB first.
  - SHIFT, `cnt` 9: capture the parity bit.
  - SHIFT, `cnt` 10: capture the stop bit, issue a 1-cycle `frame_done` pulse, go to IDLE, set `cnt`=0.
  - Watchdog: counts `clk` cycles in SHIFT and clears on every `fall`. At `TIMEOUT_CYCLES` it forces IDLE and discards the partial byte; no `frame_done` is issued.
- **Decoder** (runs on `frame_done`; flag `brk` resets to 0)
  - Code 0xF0: set `brk`; outputs unchanged.
  - Code 0xE0: ignored. The following byte is decoded as a normal code.
  - Any other code with `brk`=1: clear `brk`, drive `ps2_state`←0, hold `ps2_byte`. This applies whether or not the code is mapped.
  - Mapped code with `brk`=0: drive `ps2_byte`←ascii, `ps2_state`←1.
  - Unmapped code with `brk`=0: no output change.
- **Typematic repeat:** repeated make codes while `ps2_state`=1 keep it high and rewrite `ps2_byte`. No falling edge occurs, so the UART does not retransmit.
- **Map (set 2 → ASCII)**
  - Letters give uppercase: 0x1C→0x41 'A' … 0x1A→0x5A 'Z'.
  - Digits: 0x45→0x30, 0x16→0x31 … 0x46→0x39.
  - 0x29→0x20 (space).
  - 0x5A→0x0D (Enter).
  - All other codes are unmapped.

## Timing
- **Reset values:** `ps2_byte`=8'h00, `ps2_state`=0, FSM IDLE, `cnt`=0, `brk`=0, watchdog=0. Asserting reset mid-frame discards the frame.
- **Latency:** `ps2_byte`/`ps2_state` update on the 2nd `clk` edge after the `fall` pulse of the stop bit (1 cycle for `frame_done`, 1 for the decode register).
- `ps2_byte` is stable no later than `ps2_state` rises; the two never change in an order that lets the UART latch stale data.
- Minimum PS/2 clock low/high time handled: ≥ 4 `clk` cycles (keyboards provide ≥ 30 µs).
- **Watchdog expiry coinciding with `fall`:** `fall` wins, watchdog clears, and the bit is sampled.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: at `cnt` 10 the frame is accepted only if the odd parity over data+parity is correct and the stop bit = 1. Otherwise `frame_done` is suppressed and the frame is dropped silently; `brk` is unaffected.
- Not defined: parity and stop bits are sampled but ignored, and every complete frame issues `frame_done`.

## Structure
- **Shared package `ps2_pkg`:**
  - constants `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0.
  - frame state enum (IDLE, SHIFT).
  - `PS2_FRAME_BITS`=11.
  - scan-code→ASCII table function.
- **One sub-module `ps2_scancode_to_ascii`:** purely combinational, 8-bit code in, 8-bit ascii out plus 1-bit `mapped`.
- Sync, frame FSM, watchdog and decoder registers live in the top module.

## Test plan
- **Make code:** frame 0x1C (correct parity, stop=1) → `ps2_byte`=0x41, `ps2_state` 0→1 exactly 2 cycles after the stop-bit `fall`.
- **Break sequence:** frames 0xF0, 0x1C after press → `ps2_state`=0 after the 0x1C frame, `ps2_byte` stays 0x41.
- **Typematic:** frames 0x16, 0x16, 0x16 → `ps2_byte`=0x31, `ps2_state` rises once and stays high.
- **Parity:** frame 0x24 with wrong parity → with macro, no change on outputs; without macro, `ps2_byte`=0x45, `ps2_state`=1.
- **Timeout:** 5 bits then idle for `TIMEOUT_CYCLES`+10, then full frame 0x29 → `ps2_byte`=0x20, `ps2_state`=1. Also: reset asserted mid-frame → all outputs 0.
- **Extended/unmapped:** frames 0xE0, 0x75 → no output change. Then 0xE0, 0xF0, 0x75 with `ps2_state`=1 → `ps2_state`=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: protocol constants, frame FSM states and the
// scan-code set 2 to ASCII lookup used by the key decoder.
package ps2_pkg;

  localparam logic [7:0]  PS2_BREAK      = 8'hF0;
  localparam logic [7:0]  PS2_EXT        = 8'hE0;
  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic {
    IDLE,
    SHIFT
  } ps2_frame_state_e;

  // Returns {mapped, ascii}; unmapped codes give {1'b0, 8'h00}.
  function automatic logic [8:0] ps2_scancode_ascii(input logic [7:0] code);
    logic [8:0] r;
    r = '0;
    case (code)
      8'h1C: r = {1'b1, 8'h41}; // A
      8'h32: r = {1'b1, 8'h42}; // B
      8'h21: r = {1'b1, 8'h43}; // C
      8'h23: r = {1'b1, 8'h44}; // D
      8'h24: r = {1'b1, 8'h45}; // E
      8'h2B: r = {1'b1, 8'h46}; // F
      8'h34: r = {1'b1, 8'h47}; // G
      8'h33: r = {1'b1, 8'h48}; // H
      8'h43: r = {1'b1, 8'h49}; // I
      8'h3B: r = {1'b1, 8'h4A}; // J
      8'h42: r = {1'b1, 8'h4B}; // K
      8'h4B: r = {1'b1, 8'h4C}; // L
      8'h3A: r = {1'b1, 8'h4D}; // M
      8'h31: r = {1'b1, 8'h4E}; // N
      8'h44: r = {1'b1, 8'h4F}; // O
      8'h4D: r = {1'b1, 8'h50}; // P
      8'h15: r = {1'b1, 8'h51}; // Q
      8'h2D: r = {1'b1, 8'h52}; // R
      8'h1B: r = {1'b1, 8'h53}; // S
      8'h2C: r = {1'b1, 8'h54}; // T
      8'h3C: r = {1'b1, 8'h55}; // U
      8'h2A: r = {1'b1, 8'h56}; // V
      8'h1D: r = {1'b1, 8'h57}; // W
      8'h22: r = {1'b1, 8'h58}; // X
      8'h35: r = {1'b1, 8'h59}; // Y
      8'h1A: r = {1'b1, 8'h5A}; // Z
      8'h45: r = {1'b1, 8'h30}; // 0
      8'h16: r = {1'b1, 8'h31}; // 1
      8'h1E: r = {1'b1, 8'h32}; // 2
      8'h26: r = {1'b1, 8'h33}; // 3
      8'h25: r = {1'b1, 8'h34}; // 4
      8'h2E: r = {1'b1, 8'h35}; // 5
      8'h36: r = {1'b1, 8'h36}; // 6
      8'h3D: r = {1'b1, 8'h37}; // 7
      8'h3E: r = {1'b1, 8'h38}; // 8
      8'h46: r = {1'b1, 8'h39}; // 9
      8'h29: r = {1'b1, 8'h20}; // space
      8'h5A: r = {1'b1, 8'h0D}; // Enter
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// Combinational scan-code set 2 to ASCII translator.
module ps2_scancode_to_ascii
  import ps2_pkg::*;
(
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o,
  output logic       mapped_o
);

  // Table lookup through the shared package function.
  always_comb begin
    {mapped_o, ascii_o} = ps2_scancode_ascii(code_i);
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and make/break decoder feeding a UART transmitter.
// ps2_byte carries the ASCII of the last make code, ps2_state is the
// key-held level whose rising edge triggers one UART transmission.
// Optional build macro: PS2_PARITY_CHECK_EN drops frames with bad odd parity
// or a low stop bit.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic [7:0] ps2_byte,
  output logic       ps2_state
);

  localparam int unsigned       WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        CNT_PAR   = 4'(PS2_FRAME_BITS - 2);
  localparam logic [3:0]        CNT_STOP  = 4'(PS2_FRAME_BITS - 1);

  logic [2:0]        clk_sync_q;
  logic [1:0]        dat_sync_q;
  logic              fall;
  logic              bit_in;

  ps2_frame_state_e  state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic              parity_q, parity_d;
`endif

  logic              brk_q, brk_d;
  logic [7:0]        byte_q, byte_d;
  logic              held_q, held_d;
  logic [7:0]        map_ascii;
  logic              map_hit;

  // Synchronise the keyboard lines; idle-high reset avoids a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2k_clk};
      dat_sync_q <= {dat_sync_q[0], ps2k_data};
    end
  end

  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_in = dat_sync_q[1];

  // Frame FSM, bit counter, shifter and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      wdog_q       <= '0;
      frame_done_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      wdog_q       <= wdog_d;
      frame_done_q <= frame_done_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // Next-state logic; a falling edge takes priority over watchdog expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    wdog_d  = wdog_q;
`ifdef PS2_PARITY_CHECK_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (fall && !bit_in) begin
          state_d = SHIFT;
          cnt_d   = 4'd1;
        end
      end
      SHIFT: begin
        if (fall) begin
          wdog_d = '0;
          if (cnt_q == CNT_STOP) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q < CNT_PAR) begin
              shift_d = {bit_in, shift_q[7:1]};
            end
`ifdef PS2_PARITY_CHECK_EN
            if (cnt_q == CNT_PAR) begin
              parity_d = bit_in;
            end
`endif
          end
        end else if (wdog_q == WDOG_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          wdog_d  = '0;
          shift_d = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame acceptance: odd parity plus stop=1 when checking is built in.
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = bit_in & (^{shift_q, parity_q});
`else
    frame_ok = 1'b1;
`endif
  end

  // FSM output: one-cycle frame_done on the accepted stop bit.
  always_comb begin
    frame_done_d = 1'b0;
    if (state_q == SHIFT && fall && cnt_q == CNT_STOP) begin
      frame_done_d = frame_ok;
    end
  end

  ps2_scancode_to_ascii u_map (
    .code_i   (shift_q),
    .ascii_o  (map_ascii),
    .mapped_o (map_hit)
  );

  // Make/break decode; shift_q is stable while frame_done_q is high.
  always_comb begin
    brk_d  = brk_q;
    byte_d = byte_q;
    held_d = held_q;
    if (frame_done_q) begin
      if (shift_q == PS2_BREAK) begin
        brk_d = 1'b1;
      end else if (shift_q != PS2_EXT) begin
        if (brk_q) begin
          brk_d  = 1'b0;
          held_d = 1'b0;
        end else if (map_hit) begin
          byte_d = map_ascii;
          held_d = 1'b1;
        end
      end
    end
  end

  // Decoder registers; byte and level update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_q  <= 1'b0;
      byte_q <= '0;
      held_q <= 1'b0;
    end else begin
      brk_q  <= brk_d;
      byte_q <= byte_d;
      held_q <= held_d;
    end
  end

  assign ps2_byte  = byte_q;
  assign ps2_state = held_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder with a byte-level behavioural model.
module tb_ps2_key_decoder;

  localparam int unsigned TO = 2000;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2k_clk = 1'b1;
  logic       ps2k_data = 1'b1;
  logic [7:0] ps2_byte;
  logic       ps2_state;

  int checks = 0;
  int errors = 0;

  // Behavioural model state and reference table.
  logic [7:0] m_byte = 8'h00;
  logic       m_held = 1'b0;
  logic       m_brk  = 1'b0;
  logic [7:0] ref_ascii [256];
  bit         ref_valid [256];
  logic [7:0] valid_codes [$];

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                   8'h3D, 8'h3E, 8'h46};

  int   rise_cnt = 0;
  logic prev_state = 1'b0;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2k_clk  (ps2k_clk),
    .ps2k_data (ps2k_data),
    .ps2_byte  (ps2_byte),
    .ps2_state (ps2_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    prev_state <= ps2_state;
    if (ps2_state === 1'b1 && prev_state === 1'b0) rise_cnt++;
  end

  initial begin
    #10_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic build_ref();
    for (int i = 0; i < 256; i++) begin
      ref_ascii[i] = 8'h00;
      ref_valid[i] = 1'b0;
    end
    for (int i = 0; i < 26; i++) begin
      ref_ascii[letter_codes[i]] = 8'h41 + 8'(i);
      ref_valid[letter_codes[i]] = 1'b1;
      valid_codes.push_back(letter_codes[i]);
    end
    for (int i = 0; i < 10; i++) begin
      ref_ascii[digit_codes[i]] = 8'h30 + 8'(i);
      ref_valid[digit_codes[i]] = 1'b1;
      valid_codes.push_back(digit_codes[i]);
    end
    ref_ascii[8'h29] = 8'h20; ref_valid[8'h29] = 1'b1; valid_codes.push_back(8'h29);
    ref_ascii[8'h5A] = 8'h0D; ref_valid[8'h5A] = 1'b1; valid_codes.push_back(8'h5A);
  endtask

  task automatic model_reset();
    m_byte = 8'h00;
    m_held = 1'b0;
    m_brk  = 1'b0;
  endtask

  task automatic model_apply(input logic [7:0] code, input bit bad);
    if (PAR_EN && bad) return;
    if (code == 8'hF0) m_brk = 1'b1;
    else if (code == 8'hE0) begin end
    else if (m_brk) begin
      m_brk  = 1'b0;
      m_held = 1'b0;
    end else if (ref_valid[code]) begin
      m_byte = ref_ascii[code];
      m_held = 1'b1;
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input bit bad);
    logic par;
    par = ~^code;
    if (bad) par = ~par;
    return {1'b1, par, code, 1'b0};
  endfunction

  // Drives the first nbits of a frame (bit 0 = start); optional stall after bit stall_at.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int stall_at,
                           input int stall);
    for (int i = 0; i < nbits; i++) begin
      ps2k_data = bits[i];
      repeat ($urandom_range(4, 9)) @(negedge clk);
      ps2k_clk = 1'b0;
      repeat ($urandom_range(4, 9)) @(negedge clk);
      ps2k_clk = 1'b1;
      if (i == stall_at) repeat (stall) @(negedge clk);
    end
    ps2k_data = 1'b1;
  endtask

  task automatic send_code(input logic [7:0] code, input bit bad);
    send_bits(make_frame(code, bad), 11, -1, 0);
    model_apply(code, bad);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (ps2_byte !== 8'h00 || ps2_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_active: byte=%h state=%b expected byte=00 state=0", ps2_byte, ps2_state);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (ps2_byte !== 8'h00 || ps2_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: byte=%h state=%b expected byte=00 state=0", ps2_byte, ps2_state);
    end
  endtask

  task automatic test_make();
    logic [7:0] pb;
    logic       ph;
    pb = m_byte;
    ph = m_held;
    send_bits(make_frame(8'h1C, 1'b0), 10, -1, 0);
    model_apply(8'h1C, 1'b0);
    ps2k_data = 1'b1;
    repeat ($urandom_range(4, 9)) @(negedge clk);
    ps2k_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ps2_byte !== pb || ps2_state !== ph) begin
      errors++;
      $display("FAIL make_latency_early: byte=%h state=%b expected byte=%h state=%b",
               ps2_byte, ps2_state, pb, ph);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ps2_byte !== 8'h41 || ps2_state !== 1'b1 || m_byte !== 8'h41) begin
      errors++;
      $display("FAIL make_latency_edge: byte=%h state=%b expected byte=41 state=1",
               ps2_byte, ps2_state);
    end
    repeat (5) @(negedge clk);
    ps2k_clk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_break();
    send_code(8'hF0, 1'b0);
    checks++;
    if (ps2_byte !== m_byte || ps2_state !== 1'b1) begin
      errors++;
      $display("FAIL break_prefix: byte=%h state=%b expected byte=%h state=1",
               ps2_byte, ps2_state, m_byte);
    end
    send_code(8'h1C, 1'b0);
    checks++;
    if (ps2_byte !== 8'h41 || ps2_state !== 1'b0 || m_held !== 1'b0) begin
      errors++;
      $display("FAIL break_release: byte=%h state=%b expected byte=41 state=0",
               ps2_byte, ps2_state);
    end
  endtask

  task automatic test_typematic();
    int r0;
    r0 = rise_cnt;
    for (int i = 0; i < 3; i++) begin
      send_code(8'h16, 1'b0);
      checks++;
      if (ps2_byte !== 8'h31 || ps2_state !== 1'b1) begin
        errors++;
        $display("FAIL typematic_%0d: byte=%h state=%b expected byte=31 state=1",
                 i, ps2_byte, ps2_state);
      end
    end
    checks++;
    if (rise_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL typematic_rises: got %0d expected 1", rise_cnt - r0);
    end
  endtask

  task automatic test_parity();
    send_code(8'h1C, 1'b0);
    send_code(8'hF0, 1'b0);
    send_code(8'h1C, 1'b0);
    send_code(8'h24, 1'b1);
    checks++;
    if (ps2_byte !== m_byte || ps2_state !== m_held) begin
      errors++;
      $display("FAIL parity_bad: byte=%h state=%b expected byte=%h state=%b",
               ps2_byte, ps2_state, m_byte, m_held);
    end
    send_code(8'h24, 1'b0);
    checks++;
    if (ps2_byte !== 8'h45 || ps2_state !== 1'b1) begin
      errors++;
      $display("FAIL parity_good: byte=%h state=%b expected byte=45 state=1",
               ps2_byte, ps2_state);
    end
  endtask

  task automatic test_timeout();
    send_bits(make_frame(8'h29, 1'b0), 5, -1, 0);
    repeat (TO + 10) @(negedge clk);
    checks++;
    if (ps2_byte !== m_byte || ps2_state !== m_held) begin
      errors++;
      $display("FAIL timeout_partial: byte=%h state=%b expected byte=%h state=%b",
               ps2_byte, ps2_state, m_byte, m_held);
    end
    send_code(8'h29, 1'b0);
    checks++;
    if (ps2_byte !== 8'h20 || ps2_state !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover: byte=%h state=%b expected byte=20 state=1",
               ps2_byte, ps2_state);
    end
  endtask

  task automatic test_wdog_boundary();
    send_bits(make_frame(8'h1E, 1'b0), 11, 4, TO - 60);
    model_apply(8'h1E, 1'b0);
    repeat (8) @(negedge clk);
    checks++;
    if (ps2_byte !== 8'h32 || ps2_state !== 1'b1) begin
      errors++;
      $display("FAIL wdog_near_limit: byte=%h state=%b expected byte=32 state=1",
               ps2_byte, ps2_state);
    end
  endtask

  task automatic test_extended();
    logic [7:0] pb;
    logic       ph;
    pb = ps2_byte;
    ph = ps2_state;
    send_code(8'hE0, 1'b0);
    send_code(8'h75, 1'b0);
    checks++;
    if (ps2_byte !== pb || ps2_state !== ph || m_byte !== pb) begin
      errors++;
      $display("FAIL ext_unmapped: byte=%h state=%b expected byte=%h state=%b",
               ps2_byte, ps2_state, pb, ph);
    end
    send_code(8'h1C, 1'b0);
    send_code(8'hE0, 1'b0);
    send_code(8'hF0, 1'b0);
    send_code(8'h75, 1'b0);
    checks++;
    if (ps2_byte !== 8'h41 || ps2_state !== 1'b0) begin
      errors++;
      $display("FAIL ext_break: byte=%h state=%b expected byte=41 state=0",
               ps2_byte, ps2_state);
    end
  endtask

  task automatic test_reset_midframe();
    send_code(8'h5A, 1'b0);
    send_bits(make_frame(8'h1C, 1'b0), 5, -1, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (ps2_byte !== 8'h00 || ps2_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe: byte=%h state=%b expected byte=00 state=0",
               ps2_byte, ps2_state);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_code(8'h3A, 1'b0);
    checks++;
    if (ps2_byte !== 8'h4D || ps2_state !== 1'b1) begin
      errors++;
      $display("FAIL reset_recover: byte=%h state=%b expected byte=4D state=1",
               ps2_byte, ps2_state);
    end
  endtask

  task automatic test_random();
    logic [7:0] code;
    bit         bad;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: code = valid_codes[$urandom_range(0, valid_codes.size() - 1)];
        3:       code = 8'hF0;
        4:       code = 8'hE0;
        default: code = 8'($urandom);
      endcase
      bad = ($urandom_range(0, 7) == 0);
      send_code(code, bad);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      checks++;
      if (ps2_byte !== m_byte || ps2_state !== m_held) begin
        errors++;
        $display("FAIL random_%0d code=%h bad=%0d: byte=%h state=%b expected byte=%h state=%b",
                 i, code, bad, ps2_byte, ps2_state, m_byte, m_held);
      end
    end
  endtask

  initial begin
    build_ref();
    model_reset();
    test_reset();
    test_make();
    test_break();
    test_typematic();
    test_parity();
    test_timeout();
    test_wdog_boundary();
    test_extended();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
